// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer
//   In-core trace capture for the multicycle pipeline. Every cycle the state
//   code and one data word of each monitored stage are offered to a circular
//   buffer. Capture is started by arm and frozen by trigger, with a
//   programmable post-trigger window and an optional change-only filter.
//   Captured entries drain oldest-first to a debug reader.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   stage_state         packed stage state codes (stage 0 in the LSBs)
//   stage_data          packed stage data words (stage 0 in the LSBs)
//   arm                 start capture (IDLE only)
//   abort               flush and return to IDLE (any state, top priority)
//   trigger             freeze event (ARMED only)
//   post_cnt            samples recorded after the trigger sample
//   filter_en           record only cycles whose stage_state changed
//   out_valid/out_ready drain handshake
//   out_cycle/state/data registered drain entry
//   level               entries currently held
//   armed, triggered    status; together they encode the FSM state
//   overflow            sticky, an entry was overwritten since arm
//
// Drain handshake: an entry transfers on any rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// out_* fields hold their value. out_valid never drops without a transfer
// except on abort or reset.
module pipe_trace_buffer #(
  parameter int NUM_STAGES = 4,
  parameter int STATE_W    = 3,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int CYCLE_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_STAGES*STATE_W-1:0]  stage_state,
  input  logic [NUM_STAGES*DATA_W-1:0]   stage_data,
  input  logic                           arm,
  input  logic                           abort,
  input  logic                           trigger,
  input  logic [$clog2(DEPTH):0]         post_cnt,
  input  logic                           filter_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CYCLE_W-1:0]             out_cycle,
  output logic [NUM_STAGES*STATE_W-1:0]  out_state,
  output logic [NUM_STAGES*DATA_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           armed,
  output logic                           triggered,
  output logic                           overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int SW      = NUM_STAGES * STATE_W;
  localparam int DW      = NUM_STAGES * DATA_W;
  localparam int ENTRY_W = CYCLE_W + SW + DW;

  // Encoding chosen so that armed = state[1] and triggered = state[0];
  // {armed, triggered} is therefore a complete view of the FSM state.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b10,
    S_POST  = 2'b11,
    S_DRAIN = 2'b01
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [CYCLE_W-1:0]  cycle_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    wr_ptr_next;
  logic [LVL_W-1:0]    level_next;
  logic [LVL_W-1:0]    post_left;
  logic                first_flag;
  logic [SW-1:0]       last_state;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;
  logic [PTR_W-1:0]    rd_idx;

  logic                qual;
  logic                do_rec;
  logic                do_pop;
  logic                full;

  assign qual     = !filter_en || first_flag || (stage_state != last_state);
  assign full     = (level == LVL_W'(DEPTH));
  assign wr_entry = {cycle_cnt, stage_state, stage_data};

  // The trigger sample is recorded unconditionally; a trigger in POST has
  // no effect, so only the filter qualifies records there.
  always_comb begin
    do_rec = 1'b0;
    if (!abort) begin
      if (state == S_ARMED)     do_rec = trigger || qual;
      else if (state == S_POST) do_rec = qual;
    end
  end

  assign do_pop = !abort && (state == S_DRAIN) && out_valid && out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (arm) state_next = S_ARMED;
        S_ARMED: if (trigger) state_next = (post_cnt == '0) ? S_DRAIN : S_POST;
        // The record that brings post_left to zero still gets stored.
        S_POST:  if (qual && post_left == LVL_W'(1)) state_next = S_DRAIN;
        S_DRAIN: if (do_pop && level == LVL_W'(1)) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    armed     = state[1];
    triggered = state[0];
  end

  // ------------------------------------------------------- occupancy
  always_comb begin
    level_next = level;
    if (abort)                       level_next = '0;
    else if (state == S_IDLE && arm) level_next = '0;
    else if (do_rec && !full)        level_next = level + LVL_W'(1);
    else if (do_pop)                 level_next = level - LVL_W'(1);
  end

  assign wr_ptr_next = do_rec ? wr_ptr + PTR_W'(1) : wr_ptr;

  // Oldest entry as it will be after this edge; the output registers are
  // loaded from it so out_* are valid in the same cycle out_valid rises.
  // When the only entry is the one being written now, take it directly
  // from the write path instead of the storage.
  assign rd_idx   = wr_ptr_next - level_next[PTR_W-1:0];
  assign rd_entry = (do_rec && rd_idx == wr_ptr) ? wr_entry : mem[rd_idx];

  // ------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (do_rec) mem[wr_ptr] <= wr_entry;
  end

  // ------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      post_left  <= '0;
      overflow   <= 1'b0;
      first_flag <= 1'b0;
      last_state <= '0;
      out_valid  <= 1'b0;
      out_cycle  <= '0;
      out_state  <= '0;
      out_data   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CYCLE_W'(1);
      wr_ptr    <= wr_ptr_next;
      level     <= level_next;
      // DRAIN is never entered or kept with an empty buffer.
      out_valid <= (state_next == S_DRAIN);
      if (state_next == S_DRAIN) {out_cycle, out_state, out_data} <= rd_entry;

      if (abort) begin
        post_left <= '0;
        overflow  <= 1'b0;
      end else if (state == S_IDLE && arm) begin
        overflow   <= 1'b0;
        first_flag <= 1'b1;
      end else if (do_rec) begin
        first_flag <= 1'b0;
        last_state <= stage_state;
        if (full) overflow <= 1'b1;
        if (state == S_ARMED && trigger) post_left <= post_cnt;
        else if (state == S_POST)        post_left <= post_left - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer
//   Bench for pipe_trace_buffer with DEPTH=8. A behavioural model in the
//   driver decides which cycles are recorded and pushes the expected entries
//   to exp_q; the drain task pops and compares them as the DUT presents them.
module tb_pipe_trace_buffer;

  localparam int N_ST = 4;
  localparam int ST_W = 3;
  localparam int D_W  = 32;
  localparam int DEP  = 8;
  localparam int CY_W = 32;
  localparam int SWT  = N_ST * ST_W;
  localparam int DWT  = N_ST * D_W;
  localparam int LW   = $clog2(DEP) + 1;
  localparam int E_W  = CY_W + SWT + DWT;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DRAIN = 3;

  // ------------------------------------------------ clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SWT-1:0]  stage_state;
  logic [DWT-1:0]  stage_data;
  logic            arm;
  logic            abort;
  logic            trigger;
  logic [LW-1:0]   post_cnt;
  logic            filter_en;
  logic            out_valid;
  logic            out_ready;
  logic [CY_W-1:0] out_cycle;
  logic [SWT-1:0]  out_state;
  logic [DWT-1:0]  out_data;
  logic [LW-1:0]   level;
  logic            armed;
  logic            triggered;
  logic            overflow;

  pipe_trace_buffer #(
    .NUM_STAGES(N_ST), .STATE_W(ST_W), .DATA_W(D_W), .DEPTH(DEP), .CYCLE_W(CY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .stage_state(stage_state), .stage_data(stage_data),
    .arm(arm), .abort(abort), .trigger(trigger),
    .post_cnt(post_cnt), .filter_en(filter_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cycle(out_cycle), .out_state(out_state), .out_data(out_data),
    .level(level), .armed(armed), .triggered(triggered), .overflow(overflow)
  );

  // ------------------------------------------------ scoreboard state
  logic [E_W-1:0]  exp_q[$];
  logic [CY_W-1:0] got_stamps[$];
  logic [CY_W-1:0] cyc;
  int              m_st;
  int              m_post;
  logic            m_first;
  logic [SWT-1:0]  m_last;
  logic            m_ovf;
  int              n_total;
  int              n_bad;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    cyc = '0; m_st = M_IDLE; exp_q.delete(); m_ovf = 1'b0; m_first = 1'b0; m_last = '0;
  endtask

  function automatic logic [SWT-1:0] rnd_st();
    return SWT'($urandom_range(0, 4095));
  endfunction

  // Drives one cycle of inputs and predicts whether it gets recorded.
  task automatic step(input logic a, input logic t, input logic ab, input logic [SWT-1:0] st);
    logic [DWT-1:0] d;
    logic rec;
    logic qual;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    arm = a; trigger = t; abort = ab; stage_state = st; stage_data = d;
    rec  = 1'b0;
    qual = !filter_en || m_first || (st != m_last);
    if (ab) begin
      m_st = M_IDLE; exp_q.delete(); m_ovf = 1'b0;
    end else begin
      case (m_st)
        M_IDLE: if (a) begin m_st = M_ARMED; m_first = 1'b1; exp_q.delete(); m_ovf = 1'b0; end
        M_ARMED: begin
          if (t) begin
            rec = 1'b1; m_post = int'(post_cnt);
            m_st = (post_cnt == 0) ? M_DRAIN : M_POST;
          end else begin
            rec = qual;
          end
        end
        M_POST: if (qual) begin rec = 1'b1; m_post--; if (m_post == 0) m_st = M_DRAIN; end
        default: ;
      endcase
    end
    if (rec) begin
      exp_q.push_back({cyc, st, d});
      if (exp_q.size() > DEP) begin void'(exp_q.pop_front()); m_ovf = 1'b1; end
      m_first = 1'b0;
      m_last  = st;
    end
    tick();
    arm = 1'b0; trigger = 1'b0; abort = 1'b0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0,...
  task automatic drain(input int mode, input int max_pops);
    int k; int pops; int guard;
    logic hold;
    logic [E_W-1:0] held;
    logic [E_W-1:0] e;
    got_stamps.delete();
    k = 0; pops = 0; guard = 0; hold = 1'b0; held = '0;
    while (exp_q.size() > 0 && pops < max_pops && guard < 100) begin
      out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_level", level, exp_q.size());
      if (hold) chk("drain_held", {out_cycle, out_state, out_data}, held);
      held = {out_cycle, out_state, out_data};
      hold = !out_ready;
      if (out_ready) begin
        e = exp_q.pop_front();
        chk("drain_entry", {out_cycle, out_state, out_data}, e);
        got_stamps.push_back(out_cycle);
        pops++;
      end
      tick();
      k++; guard++;
    end
    out_ready = 1'b0;
    chk("drain_bound", guard < 100, 1'b1);
    if (exp_q.size() == 0) begin
      m_st = M_IDLE;
      chk("post_drain_valid", out_valid, 1'b0);
      chk("post_drain_state", {armed, triggered}, 2'b00);
      chk("post_drain_level", level, 0);
    end
  endtask

  task automatic chk_flushed(input string tag);
    chk({tag, "_state"}, {armed, triggered}, 2'b00);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
  endtask

  // ------------------------------------------------ watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------ stimulus
  logic [CY_W-1:0] trig_stamp;

  initial begin
    n_total = 0; n_bad = 0; cyc = '0;
    m_st = M_IDLE; m_post = 0; m_first = 1'b0; m_last = '0; m_ovf = 1'b0;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0; post_cnt = '0;
    filter_en = 1'b0; out_ready = 1'b0; stage_state = '0; stage_data = '0;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_state", {armed, triggered}, 2'b00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_out", {out_cycle, out_state, out_data}, 0);
    do_reset();

    // Basic window: arm at 10, trigger at 15, two post samples.
    while (cyc < 10) step(1'b0, 1'b0, 1'b0, rnd_st());
    step(1'b1, 1'b0, 1'b0, rnd_st());
    post_cnt = 2;
    while (cyc < 15) step(1'b0, 1'b0, 1'b0, rnd_st());
    step(1'b0, 1'b1, 1'b0, rnd_st());
    while (m_st == M_POST) step(1'b0, 1'b0, 1'b0, rnd_st());
    chk("t1_level", level, 7);
    chk("t1_ovf", overflow, 1'b0);
    chk("t1_drain_state", {armed, triggered}, 2'b01);
    drain(0, 100);
    chk("t1_count", got_stamps.size(), 7);
    for (int i = 0; i < got_stamps.size(); i++) chk("t1_stamp", got_stamps[i], 11 + i);

    // Overflow: trigger 20 cycles after arm, three post samples.
    do_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, rnd_st());
    step(1'b1, 1'b0, 1'b0, rnd_st());
    repeat (19) step(1'b0, 1'b0, 1'b0, rnd_st());
    post_cnt = 3;
    trig_stamp = cyc;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    while (m_st == M_POST) step(1'b0, 1'b0, 1'b0, rnd_st());
    chk("t2_level", level, DEP);
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_ovf_model", overflow, m_ovf);
    drain(0, 100);
    chk("t2_count", got_stamps.size(), DEP);
    chk("t2_first", got_stamps.size() > 0 ? got_stamps[0] : '1, trig_stamp - 4);
    chk("t2_last", got_stamps.size() > 0 ? got_stamps[got_stamps.size() - 1] : '1, trig_stamp + 3);
    chk("t2_ovf_sticky", overflow, 1'b1);

    // Change-only filter: state changes at 30 and 34, trigger at 40.
    do_reset();
    filter_en = 1'b1;
    post_cnt  = 0;
    while (cyc < 25) step(1'b0, 1'b0, 1'b0, SWT'(1));
    step(1'b1, 1'b0, 1'b0, SWT'(1));
    while (cyc < 40) step(1'b0, 1'b0, 1'b0, (cyc >= 34) ? SWT'(5) : (cyc >= 30) ? SWT'(2) : SWT'(1));
    step(1'b0, 1'b1, 1'b0, SWT'(5));
    chk("t3_level", level, 4);
    chk("t3_drain_state", {armed, triggered}, 2'b01);
    drain(0, 100);
    chk("t3_count", got_stamps.size(), 4);
    chk("t3_s0", got_stamps.size() > 0 ? got_stamps[0] : '1, 26);
    chk("t3_s1", got_stamps.size() > 1 ? got_stamps[1] : '1, 30);
    chk("t3_s2", got_stamps.size() > 2 ? got_stamps[2] : '1, 34);
    chk("t3_s3", got_stamps.size() > 3 ? got_stamps[3] : '1, 40);
    filter_en = 1'b0;

    // Drain under backpressure.
    do_reset();
    step(1'b1, 1'b0, 1'b0, rnd_st());
    repeat (4) step(1'b0, 1'b0, 1'b0, rnd_st());
    post_cnt = 2;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    while (m_st == M_POST) step(1'b0, 1'b0, 1'b0, rnd_st());
    drain(1, 100);
    chk("t4_count", got_stamps.size(), 7);
    for (int i = 1; i < got_stamps.size(); i++) chk("t4_seq", got_stamps[i], got_stamps[i - 1] + 1);

    // Abort in POST after an overflow; a second trigger is ignored first.
    do_reset();
    step(1'b1, 1'b0, 1'b0, rnd_st());
    repeat (10) step(1'b0, 1'b0, 1'b0, rnd_st());
    post_cnt = 5;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    step(1'b0, 1'b0, 1'b0, rnd_st());
    chk("t5_post_state", {armed, triggered}, 2'b11);
    chk("t5_pre_ovf", overflow, 1'b1);
    post_cnt = 7;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    step(1'b0, 1'b0, 1'b1, rnd_st());
    chk_flushed("t5_abort_post");

    // A trigger inside POST must not reload the window.
    step(1'b1, 1'b0, 1'b0, rnd_st());
    repeat (2) step(1'b0, 1'b0, 1'b0, rnd_st());
    post_cnt = 3;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    post_cnt = 7;
    step(1'b0, 1'b1, 1'b0, rnd_st());
    repeat (2) step(1'b0, 1'b0, 1'b0, rnd_st());
    chk("t5_no_reload_state", {armed, triggered}, 2'b01);
    chk("t5_no_reload_level", level, 6);
    drain(0, 2);
    chk("t5_mid_drain_level", level, 4);
    step(1'b0, 1'b0, 1'b1, rnd_st());
    chk_flushed("t5_abort_drain");

    // Asynchronous reset while ARMED, then a single-sample capture.
    do_reset();
    step(1'b1, 1'b0, 1'b0, rnd_st());
    repeat (3) step(1'b0, 1'b0, 1'b0, rnd_st());
    chk("t6_armed", {armed, triggered}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_state", {armed, triggered}, 2'b00);
    chk("t6_async_level", level, 0);
    chk("t6_async_out", {out_valid, overflow, out_cycle, out_state, out_data}, 0);
    do_reset();
    post_cnt = 0;
    step(1'b1, 1'b0, 1'b0, rnd_st());
    step(1'b0, 1'b1, 1'b0, rnd_st());
    chk("t6_drain_state", {armed, triggered}, 2'b01);
    chk("t6_level", level, 1);
    drain(0, 100);
    chk("t6_count", got_stamps.size(), 1);
    chk("t6_stamp", got_stamps.size() > 0 ? got_stamps[0] : '1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesizable, parametrised in-core trace capture for the multicycle pipeline. Each cycle it samples the state code and one data word from NUM_STAGES stages (fetch/decode/exec/writeback by default) into a circular buffer. It supports trigger-and-freeze with a programmable post-trigger window and an optional change-only filter. Captured entries drain oldest-first over a valid/ready port to a debug reader.

Parameters:
NUM_STAGES, 4, number of monitored pipeline stages
STATE_W, 3, width of each stage state code
DATA_W, 32, width of each stage data word (pc, instruction, rd value, ...)
DEPTH, 64, buffer entries; must be a power of two, minimum 2
CYCLE_W, 32, width of the free-running cycle stamp

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
stage_state  in  NUM_STAGES*STATE_W  packed stage states; stage 0 in the LSBs
stage_data  in  NUM_STAGES*DATA_W  packed stage data; stage 0 in the LSBs
arm  in  1  start capture; honoured only in IDLE
abort  in  1  flush buffer and return to IDLE from any state
trigger  in  1  freeze event; honoured only in ARMED
post_cnt  in  log2(DEPTH)+1  samples to record after the trigger sample; sampled when trigger is accepted
filter_en  in  1  1 = record only cycles whose stage_state differs from the last recorded sample
out_valid  out  1  drain entry available
out_ready  in  1  reader accepts the entry
out_cycle  out  CYCLE_W  cycle stamp of the drain entry
out_state  out  NUM_STAGES*STATE_W  states of the drain entry
out_data  out  NUM_STAGES*DATA_W  data of the drain entry
level  out  log2(DEPTH)+1  valid entries currently held
armed  out  1  high in ARMED or POST
triggered  out  1  high in POST or DRAIN
overflow  out  1  sticky; at least one entry was overwritten since arm

Behaviour:
- Reset: state IDLE; wr_ptr, level, cycle counter, post_left, overflow, armed, triggered, out_valid all 0; out_* data 0.
- cycle_cnt increments by 1 every cycle from reset in every state and wraps modulo 2^CYCLE_W. Its value is the stamp of the sample taken that cycle.
- States: IDLE, ARMED, POST, DRAIN.
- IDLE: on arm, clear level and overflow, set first_flag, go to ARMED next cycle. Nothing is recorded on the arm cycle.
- Record qualification, ARMED/POST only: record if filter_en=0, or first_flag=1, or stage_state differs from last_state. The trigger cycle always records. A write stores {cycle_cnt, stage_state, stage_data} at wr_ptr. wr_ptr advances modulo DEPTH, last_state is updated, and first_flag is cleared.
- Full buffer write: if level==DEPTH, the oldest entry is overwritten, level stays DEPTH, and overflow is set.
- ARMED: on trigger, record the sample and load post_left=post_cnt. If post_cnt==0, go to DRAIN; otherwise go to POST.
- POST: each qualifying record decrements post_left. The record that brings post_left to 0 is stored, then the state moves to DRAIN. Non-qualifying cycles do not decrement. A trigger in POST is ignored.
- DRAIN: no recording. Oldest index = (wr_ptr - level) mod DEPTH. out_valid = (level!=0). out_* are registered and show the oldest entry whenever out_valid=1.
- Pop rule: on out_valid & out_ready, level decrements and out_* present the next entry in the following cycle. Throughput is one entry per cycle.
- When level reaches 0 in DRAIN, go to IDLE. overflow stays set until the next arm.
- Entering DRAIN with level==0 is not possible, since the trigger sample is always written.
- abort has priority over every other input in every state: go to IDLE next cycle, clear level, post_left, out_valid and overflow. The cycle counter is not affected.
- arm outside IDLE and trigger outside ARMED have no effect.
- Reset asserted mid-capture or mid-drain: all state is lost immediately. The buffer RAM contents do not need to be cleared, because level=0 makes them unreachable.
- Buffer storage: may be flops or inferred RAM. The read path must still meet the registered-output timing stated above.

Test Plan:
- DEPTH=8, filter_en=0: arm at cycle 10, trigger at cycle 15, post_cnt=2 -> samples for cycles 11..17 captured (7 entries), level=7, overflow=0; drain with out_ready=1 yields out_cycle 11,12,...,17 on consecutive cycles, then IDLE.
- DEPTH=8: arm, trigger 20 cycles later, post_cnt=3 -> overflow=1, level=8; drained stamps are the last 8 recorded, strictly increasing by 1, ending at the trigger stamp + 3.
- filter_en=1, stage_state constant except changes at stamps 30 and 34, trigger at 40, post_cnt=0 -> entries: first sample after arm, 30, 34, 40 (level=4).
- Drain backpressure: out_ready toggled 1,0,0,1,... -> no entry skipped or duplicated, and out_* held stable while out_valid & ~out_ready.
- abort asserted in POST, and separately mid-DRAIN -> next cycle IDLE, level=0, out_valid=0, overflow=0; an extra trigger in POST is ignored and post_left is not reloaded.
- rst pulsed asynchronously (between clock edges) during ARMED -> outputs return to 0 immediately and the cycle counter restarts at 0 after release; trigger with post_cnt=0 -> exactly 1 entry, DRAIN on the next cycle.
